// File: rtl/tahmin_tablo_denetleyici.sv
// tahmin_tablo_denetleyici
// Controller for a 1024-entry table of 2-bit saturating branch counters held in
// an external single-port RAM (one-cycle read latency). After reset it clears
// every entry to weak not-taken. After that it serves fetch lookups and applies
// queued resolved-branch updates as read-modify-write sequences.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   getir_istek/_ps        fetch lookup request and PC (index = PC[11:2])
//   getir_kabul            lookup granted this cycle (combinational)
//   sonuc_gecerli/_dallan  lookup result, one cycle after the grant
//   yurut_gecerli/_ps/_dallan  resolved-branch update (index = PC[11:2])
//   yurut_hazir            update queue can accept an entry this cycle
//   tablo_adres/_yaz/_yaz_veri/_oku_veri  single-port table RAM interface
//   hazir                  table initialisation finished
//   dusen_sayac            number of dropped updates, saturating at 255
module tahmin_tablo_denetleyici (
    input  logic        clk,
    input  logic        rst,
    input  logic        getir_istek,
    input  logic [31:0] getir_ps,
    output logic        getir_kabul,
    output logic        sonuc_gecerli,
    output logic        sonuc_dallan,
    input  logic        yurut_gecerli,
    input  logic [31:0] yurut_ps,
    input  logic        yurut_dallan,
    output logic        yurut_hazir,
    output logic [9:0]  tablo_adres,
    output logic        tablo_yaz,
    output logic [1:0]  tablo_yaz_veri,
    input  logic [1:0]  tablo_oku_veri,
    output logic        hazir,
    output logic [7:0]  dusen_sayac
);

    typedef enum logic [1:0] {TEMIZLE, BOSTA, G_OKU, G_YAZ} durum_t;

    durum_t      durum;
    logic [9:0]  temizle_sayac;
    logic        hazir_q;
    logic        sonuc_gecerli_q;
    logic [1:0]  okunan;
    logic [7:0]  dusen_q;

    // Update queue entries are {index[9:0], taken}.
    logic [10:0] fifo [4];
    logic [1:0]  bas;
    logic [1:0]  kuyruk;
    logic [2:0]  sayi;

    logic        fifo_dolu;
    logic        fifo_bos;
    logic [9:0]  bas_indeks;
    logic        bas_dallan;
    logic        ekle;
    logic        cikar;
    logic        dusur;
    logic        guncelle_bas;
    logic [1:0]  guncel;

    // Only the index bits of the PCs are used.
    logic        unused_ps_bits;
    assign unused_ps_bits = ^{getir_ps[31:12], getir_ps[1:0], yurut_ps[31:12], yurut_ps[1:0]};

    assign fifo_dolu  = (sayi == 3'd4);
    assign fifo_bos   = (sayi == 3'd0);
    assign bas_indeks = fifo[bas][10:1];
    assign bas_dallan = fifo[bas][0];

    assign yurut_hazir = !rst && hazir_q && !fifo_dolu;
    assign ekle        = yurut_gecerli && yurut_hazir;
    assign dusur       = yurut_gecerli && !yurut_hazir;
    assign cikar       = !rst && (durum == G_YAZ);

    // Updates win over lookups when the queue is full, or when fetch is idle.
    assign guncelle_bas = (durum == BOSTA) && (fifo_dolu || (!fifo_bos && !getir_istek));
    assign getir_kabul  = !rst && (durum == BOSTA) && !guncelle_bas && getir_istek;

    assign sonuc_gecerli = !rst && sonuc_gecerli_q;
    assign sonuc_dallan  = sonuc_gecerli && tablo_oku_veri[1];
    assign hazir         = hazir_q;
    assign dusen_sayac   = dusen_q;

    always_comb begin
        guncel = okunan;
        if (bas_dallan) begin
            if (okunan != 2'b11) guncel = okunan + 2'd1;
        end else begin
            if (okunan != 2'b00) guncel = okunan - 2'd1;
        end
    end

    // RAM port: reads and writes never share a cycle; held idle during reset.
    always_comb begin
        tablo_adres    = '0;
        tablo_yaz      = 1'b0;
        tablo_yaz_veri = '0;
        if (!rst) begin
            unique case (durum)
                TEMIZLE: begin
                    tablo_adres    = temizle_sayac;
                    tablo_yaz      = 1'b1;
                    tablo_yaz_veri = 2'b01;
                end
                BOSTA: begin
                    if (guncelle_bas) begin
                        tablo_adres = bas_indeks;
                    end else if (getir_istek) begin
                        tablo_adres = getir_ps[11:2];
                    end
                end
                G_OKU: begin
                    tablo_adres = bas_indeks;
                end
                G_YAZ: begin
                    tablo_adres    = bas_indeks;
                    tablo_yaz      = 1'b1;
                    tablo_yaz_veri = guncel;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum           <= TEMIZLE;
            temizle_sayac   <= '0;
            hazir_q         <= 1'b0;
            sonuc_gecerli_q <= 1'b0;
            okunan          <= '0;
            dusen_q         <= '0;
            bas             <= '0;
            kuyruk          <= '0;
            sayi            <= '0;
        end else begin
            sonuc_gecerli_q <= getir_kabul;

            if (dusur && (dusen_q != 8'hFF)) dusen_q <= dusen_q + 8'd1;

            if (ekle) begin
                fifo[kuyruk] <= {yurut_ps[11:2], yurut_dallan};
                kuyruk       <= kuyruk + 2'd1;
            end
            if (cikar) bas <= bas + 2'd1;

            unique case ({ekle, cikar})
                2'b10:   sayi <= sayi + 3'd1;
                2'b01:   sayi <= sayi - 3'd1;
                default: sayi <= sayi;
            endcase

            unique case (durum)
                TEMIZLE: begin
                    temizle_sayac <= temizle_sayac + 10'd1;
                    if (temizle_sayac == 10'd1023) begin
                        durum   <= BOSTA;
                        hazir_q <= 1'b1;
                    end
                end
                BOSTA: begin
                    if (guncelle_bas) durum <= G_OKU;
                end
                G_OKU: begin
                    okunan <= tablo_oku_veri;
                    durum  <= G_YAZ;
                end
                G_YAZ: begin
                    durum <= BOSTA;
                end
                default: durum <= TEMIZLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tahmin_tablo_denetleyici.sv
// Testbench for tahmin_tablo_denetleyici: models the single-port table RAM,
// applies a table of update/lookup vectors and hand-written sequences for the
// full-queue and reset-during-update corner cases.
module tb_tahmin_tablo_denetleyici;

    logic        clk = 1'b0;
    logic        rst;
    logic        getir_istek;
    logic [31:0] getir_ps;
    logic        getir_kabul;
    logic        sonuc_gecerli;
    logic        sonuc_dallan;
    logic        yurut_gecerli;
    logic [31:0] yurut_ps;
    logic        yurut_dallan;
    logic        yurut_hazir;
    logic [9:0]  tablo_adres;
    logic        tablo_yaz;
    logic [1:0]  tablo_yaz_veri;
    logic [1:0]  tablo_oku_veri;
    logic        hazir;
    logic [7:0]  dusen_sayac;

    always #5 clk = ~clk;

    tahmin_tablo_denetleyici dut (
        .clk            (clk),
        .rst            (rst),
        .getir_istek    (getir_istek),
        .getir_ps       (getir_ps),
        .getir_kabul    (getir_kabul),
        .sonuc_gecerli  (sonuc_gecerli),
        .sonuc_dallan   (sonuc_dallan),
        .yurut_gecerli  (yurut_gecerli),
        .yurut_ps       (yurut_ps),
        .yurut_dallan   (yurut_dallan),
        .yurut_hazir    (yurut_hazir),
        .tablo_adres    (tablo_adres),
        .tablo_yaz      (tablo_yaz),
        .tablo_yaz_veri (tablo_yaz_veri),
        .tablo_oku_veri (tablo_oku_veri),
        .hazir          (hazir),
        .dusen_sayac    (dusen_sayac)
    );

    // RAM model plus write monitor. Writes while hazir=0 are clear writes and are
    // checked for ascending address and data 01; later writes are logged.
    logic [1:0] mem [1024];
    int         init_idx;
    int         init_err;
    int         wr_count = 0;
    logic [9:0] last_adr;
    logic [1:0] last_veri;

    always @(posedge clk) begin
        if (tablo_yaz) mem[tablo_adres] <= tablo_yaz_veri;
        tablo_oku_veri <= mem[tablo_adres];
        if (rst) begin
            init_idx = 0;
            init_err = 0;
        end else if (tablo_yaz) begin
            if (!hazir) begin
                if (tablo_adres != init_idx[9:0] || tablo_yaz_veri != 2'b01) init_err++;
                init_idx++;
            end else begin
                wr_count++;
                last_adr  = tablo_adres;
                last_veri = tablo_yaz_veri;
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic wait_init(input string name);
        logic       prev_yaz = 1'b0;
        logic [9:0] prev_adr = '0;
        bit         seen = 1'b0;
        for (int n = 0; n < 1100 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (hazir) seen = 1'b1;
            else begin
                prev_yaz = tablo_yaz;
                prev_adr = tablo_adres;
            end
        end
        check({name, "_done"}, 32'(seen), 1);
        check({name, "_writes"}, init_idx, 1024);
        check({name, "_order"}, init_err, 0);
        check({name, "_last_wr"}, {21'd0, prev_yaz, prev_adr}, {21'd0, 1'b1, 10'h3FF});
    endtask

    task automatic do_update(input logic [31:0] ps, input logic t, input logic [9:0] exp_adr,
                             input logic [1:0] exp_veri, input string name);
        int n0;
        bit got = 1'b0;
        @(negedge clk);
        yurut_gecerli = 1'b1;
        yurut_ps      = ps;
        yurut_dallan  = t;
        n0            = wr_count;
        #1;
        check({name, "_hazir"}, 32'(yurut_hazir), 1);
        @(negedge clk);
        yurut_gecerli = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (wr_count != n0) got = 1'b1;
            else @(negedge clk);
        end
        check({name, "_wr"}, 32'(got), 1);
        check({name, "_adr"}, 32'(last_adr), 32'(exp_adr));
        check({name, "_veri"}, 32'(last_veri), 32'(exp_veri));
    endtask

    task automatic do_lookup(input logic [31:0] ps, input logic [9:0] exp_adr, input logic exp_t,
                             input string name);
        bit got = 1'b0;
        @(negedge clk);
        getir_istek = 1'b1;
        getir_ps    = ps;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (getir_kabul) got = 1'b1;
            else @(negedge clk);
        end
        check({name, "_kabul"}, 32'(got), 1);
        check({name, "_adr"}, 32'(tablo_adres), 32'(exp_adr));
        check({name, "_yaz"}, 32'(tablo_yaz), 0);
        @(negedge clk);
        getir_istek = 1'b0;
        #1;
        check({name, "_gecerli"}, 32'(sonuc_gecerli), 1);
        check({name, "_dallan"}, 32'(sonuc_dallan), 32'(exp_t));
    endtask

    typedef struct packed {
        logic        guncelle;  // 1 = update, 0 = lookup
        logic [31:0] ps;
        logic        dallan;
        logic [9:0]  adr;
        logic [1:0]  beklenen;  // write data for updates, bit 0 = taken for lookups
    } vek_t;

    vek_t vekt [13];

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int nseen;
        bit got;

        vekt[0]  = '{1'b1, 32'h0000_0040, 1'b1, 10'h010, 2'b10};
        vekt[1]  = '{1'b1, 32'h0000_0040, 1'b1, 10'h010, 2'b11};
        vekt[2]  = '{1'b0, 32'h0000_0040, 1'b0, 10'h010, 2'b01};
        vekt[3]  = '{1'b1, 32'h0000_0040, 1'b1, 10'h010, 2'b11};
        vekt[4]  = '{1'b1, 32'h0000_0080, 1'b0, 10'h020, 2'b00};
        vekt[5]  = '{1'b1, 32'h0000_0080, 1'b0, 10'h020, 2'b00};
        vekt[6]  = '{1'b0, 32'h0000_0080, 1'b0, 10'h020, 2'b00};
        vekt[7]  = '{1'b1, 32'h0000_1004, 1'b1, 10'h001, 2'b10};
        vekt[8]  = '{1'b0, 32'h0000_0004, 1'b0, 10'h001, 2'b01};
        vekt[9]  = '{1'b1, 32'h0000_0FFC, 1'b0, 10'h3FF, 2'b00};
        vekt[10] = '{1'b0, 32'h0000_0FFC, 1'b0, 10'h3FF, 2'b00};
        vekt[11] = '{1'b1, 32'h0000_0040, 1'b0, 10'h010, 2'b10};
        vekt[12] = '{1'b0, 32'h0000_0040, 1'b0, 10'h010, 2'b01};

        // Reset with requests pending: every output must stay quiet.
        rst           = 1'b1;
        getir_istek   = 1'b1;
        getir_ps      = 32'h0000_0040;
        yurut_gecerli = 1'b1;
        yurut_ps      = '0;
        yurut_dallan  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hazir", 32'(hazir), 0);
        check("rst_kabul", 32'(getir_kabul), 0);
        check("rst_sonuc_gecerli", 32'(sonuc_gecerli), 0);
        check("rst_sonuc_dallan", 32'(sonuc_dallan), 0);
        check("rst_yurut_hazir", 32'(yurut_hazir), 0);
        check("rst_tablo_yaz", 32'(tablo_yaz), 0);
        check("rst_dusen", 32'(dusen_sayac), 0);

        yurut_gecerli = 1'b0;
        rst           = 1'b0;
        #1;
        check("temizle_kabul", 32'(getir_kabul), 0);
        check("temizle_yurut_hazir", 32'(yurut_hazir), 0);
        check("temizle_ilk_yaz", {20'd0, tablo_yaz, tablo_adres, tablo_yaz_veri},
              {20'd0, 1'b1, 10'h000, 2'b01});
        getir_istek = 1'b0;
        wait_init("init1");

        do_lookup(32'h0000_0040, 10'h010, 1'b0, "req039");

        for (int i = 0; i < 13; i++) begin
            if (vekt[i].guncelle)
                do_update(vekt[i].ps, vekt[i].dallan, vekt[i].adr, vekt[i].beklenen,
                          $sformatf("v%0d", i));
            else
                do_lookup(vekt[i].ps, vekt[i].adr, vekt[i].beklenen[0], $sformatf("v%0d", i));
        end

        // Full queue while fetch keeps requesting; a fifth update is dropped.
        @(negedge clk);
        getir_istek = 1'b1;
        getir_ps    = 32'h0000_0100;
        for (int k = 0; k < 4; k++) begin
            yurut_gecerli = 1'b1;
            yurut_ps      = 32'h0000_0140 + 32'(4 * k);
            yurut_dallan  = 1'b1;
            #1;
            check($sformatf("dolu_push%0d_kabul", k), 32'(getir_kabul), 1);
            check($sformatf("dolu_push%0d_hazir", k), 32'(yurut_hazir), 1);
            @(negedge clk);
        end
        yurut_ps = 32'h0000_0150;
        #1;
        check("dolu_issue_kabul", 32'(getir_kabul), 0);
        check("dolu_issue_hazir", 32'(yurut_hazir), 0);
        check("dolu_issue_port", {21'd0, tablo_yaz, tablo_adres}, {21'd0, 1'b0, 10'h050});
        @(negedge clk);
        yurut_gecerli = 1'b0;
        #1;
        check("dolu_oku_kabul", 32'(getir_kabul), 0);
        check("dolu_dusen", 32'(dusen_sayac), 1);
        @(negedge clk);
        #1;
        check("dolu_yaz_kabul", 32'(getir_kabul), 0);
        check("dolu_yaz_port", {19'd0, tablo_yaz, tablo_adres, tablo_yaz_veri},
              {19'd0, 1'b1, 10'h050, 2'b10});
        @(negedge clk);
        #1;
        check("dolu_sonra_kabul", 32'(getir_kabul), 1);
        @(negedge clk);
        getir_istek = 1'b0;
        nseen = wr_count;
        for (int j = 1; j < 4; j++) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                #1;
                if (wr_count > nseen) got = 1'b1;
                else @(negedge clk);
            end
            nseen++;
            check($sformatf("bosalt%0d_wr", j), 32'(got), 1);
            check($sformatf("bosalt%0d_adr", j), 32'(last_adr), 32'h050 + 32'(j));
            check($sformatf("bosalt%0d_veri", j), 32'(last_veri), 32'h2);
        end

        // Reset in G_OKU with three entries queued.
        @(negedge clk);
        getir_istek = 1'b1;
        getir_ps    = '0;
        for (int k = 0; k < 3; k++) begin
            yurut_gecerli = 1'b1;
            yurut_ps      = 32'h0000_0200 + 32'(4 * k);
            yurut_dallan  = 1'b1;
            @(negedge clk);
        end
        yurut_gecerli = 1'b0;
        getir_istek   = 1'b0;
        #1;
        check("rstg_issue_port", {21'd0, tablo_yaz, tablo_adres}, {21'd0, 1'b0, 10'h080});
        nseen = wr_count;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstg_yaz", 32'(tablo_yaz), 0);
        check("rstg_kabul", 32'(getir_kabul), 0);
        @(negedge clk);
        #1;
        check("rstg_hazir", 32'(hazir), 0);
        check("rstg_dusen", 32'(dusen_sayac), 0);
        check("rstg_no_update_wr", wr_count, nseen);
        rst           = 1'b0;
        yurut_gecerli = 1'b1;
        yurut_ps      = 32'h0000_0300;
        #1;
        check("rstg_temizle0", {20'd0, tablo_yaz, tablo_adres, tablo_yaz_veri},
              {20'd0, 1'b1, 10'h000, 2'b01});
        @(negedge clk);
        yurut_gecerli = 1'b0;
        #1;
        check("rstg_temizle_dusen", 32'(dusen_sayac), 1);
        wait_init("init2");
        repeat (8) @(negedge clk);
        #1;
        check("rstg_fifo_bos", wr_count, nseen);
        check("rstg_yurut_hazir", 32'(yurut_hazir), 1);
        do_lookup(32'h0000_0200, 10'h080, 1'b0, "rstg_lookup");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
